servo_pwm_multi: RTL

Parameterised multi-channel servo PWM generator. It drives N_CH hobby servos (e.g. pan/tilt/trigger) from one shared frame counter. Position updates arrive over a valid/ready handshake and are double-buffered so they apply only at frame boundaries, so a pulse is never glitched mid-frame. An optional per-frame slew limiter smooths large position jumps.

---
 rtl/servo_pwm_multi_if.sv | 14 +
 rtl/servo_pwm_multi.sv | 106 ++++++++++
 2 files changed

// File: rtl/servo_pwm_multi_if.sv
`timescale 1ns/1ps
// Position update handshake between a producer and servo_pwm_multi.
// Channel i occupies pos_in[i*POS_W +: POS_W].
interface servo_pwm_multi_if #(
    parameter int N_CH  = 2,
    parameter int POS_W = 8
);
    logic [N_CH*POS_W-1:0] pos_in;
    logic                  pos_valid;
    logic                  pos_ready;

    modport master (output pos_in, output pos_valid, input pos_ready);
    modport slave  (input pos_in, input pos_valid, output pos_ready);
endinterface

// File: rtl/servo_pwm_multi.sv
`timescale 1ns/1ps
// Multi-channel servo PWM generator: one shared frame counter, double-buffered
// position updates applied only at frame boundaries, optional per-frame slew limit.
module servo_pwm_multi #(
    parameter int N_CH      = 2,
    parameter int POS_W     = 8,
    parameter int CNT_W     = 20,
    parameter int PERIOD    = 1000000,
    parameter int MIN_PULSE = 50000,
    parameter int STEP      = 196,
    parameter int SLEW_MAX  = 0,
    parameter int RESET_POS = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    servo_pwm_multi_if.slave pos_bus,
    output logic [N_CH-1:0]  servo_pulse,
    output logic             frame_start
);
    localparam int WW       = CNT_W + POS_W + 33;
    localparam int POS_MAX  = (1 << POS_W) - 1;
    localparam int SLEW_LIM = (SLEW_MAX > POS_MAX) ? POS_MAX : SLEW_MAX;
    localparam logic signed [POS_W:0] SLEW_S   = (POS_W+1)'(SLEW_LIM);
    localparam logic [POS_W-1:0]      RST_POS  = POS_W'(RESET_POS);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PERIOD - 1);

    typedef logic [N_CH-1:0][POS_W-1:0] pos_vec_t;

    function automatic logic [CNT_W-1:0] sat_width(input logic [POS_W-1:0] pos);
        logic [WW-1:0] full;
        full = WW'(MIN_PULSE) + WW'(pos) * WW'(STEP);
        if (full > WW'(PERIOD - 1)) return CNT_LAST;
        return full[CNT_W-1:0];
    endfunction

    // Move cur toward tgt by at most SLEW_LIM; never passes tgt.
    function automatic logic [POS_W-1:0] slew_step(input logic [POS_W-1:0] tgt,
                                                   input logic [POS_W-1:0] cur);
        logic signed [POS_W:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (SLEW_MAX == 0) return tgt;
        if (diff > SLEW_S) return cur + POS_W'(SLEW_LIM);
        if (diff < -SLEW_S) return cur - POS_W'(SLEW_LIM);
        return tgt;
    endfunction

    logic [CNT_W-1:0] cnt_p0;
    logic             en_p0;
    logic             pending_p0;
    pos_vec_t         shadow_p0, target_p0, active_p0;

    logic             boundary, xfer;
    logic [CNT_W-1:0] cnt_next;
    pos_vec_t         target_next, active_next;
    logic [N_CH-1:0]  pulse_next;

    assign pos_bus.pos_ready = ~pending_p0;
    assign xfer              = pos_bus.pos_valid & ~pending_p0;

    always_comb begin
        boundary    = enable & (~en_p0 | (cnt_p0 == CNT_LAST));
        cnt_next    = (enable & ~boundary) ? cnt_p0 + CNT_W'(1) : '0;
        target_next = (boundary & pending_p0) ? shadow_p0 : target_p0;
        active_next = active_p0;
        pulse_next  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (boundary) active_next[i] = slew_step(target_next[i], active_p0[i]);
            pulse_next[i] = enable & (cnt_next < sat_width(active_next[i]));
        end
    end

    // Stage p0: frame counter, handshake buffering, boundary position update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0     <= '0;
            en_p0      <= 1'b0;
            pending_p0 <= 1'b0;
            shadow_p0  <= {N_CH{RST_POS}};
            target_p0  <= {N_CH{RST_POS}};
            active_p0  <= {N_CH{RST_POS}};
        end else begin
            cnt_p0    <= cnt_next;
            en_p0     <= enable;
            target_p0 <= target_next;
            active_p0 <= active_next;
            if (xfer) begin
                shadow_p0  <= pos_bus.pos_in;
                pending_p0 <= 1'b1;
            end else if (boundary) begin
                pending_p0 <= 1'b0;
            end
        end
    end

    // Stage p1: registered outputs for the coming cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            servo_pulse <= '0;
            frame_start <= 1'b0;
        end else begin
            servo_pulse <= pulse_next;
            frame_start <= boundary;
        end
    end
endmodule
